// File: rtl/add_serial_sched_if.sv
// Bundle of the requester, response and serial-adder signals around add_serial_sched.
// The slave modport is the scheduler's view; the master modport is the surrounding logic.
interface add_serial_sched_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  adder_en;
  logic [WIDTH-1:0]      adder_a;
  logic [WIDTH-1:0]      adder_b;
  logic [WIDTH-1:0]      adder_out;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, adder_out,
    output req_ready, rsp_valid, rsp_id, rsp_sum, adder_en, adder_a, adder_b, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, adder_out,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, adder_en, adder_a, adder_b, busy
  );
endinterface

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
// One operation in flight; operands stay stable from launch until the result is retired.
module add_serial_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int LAT   = 10
) (
  input  logic              clk,
  input  logic              rst,
  add_serial_sched_if.slave bus
);
  localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   ptr_next_s;
  logic [IDW-1:0]   grant_s;
  logic             grant_vld_s;
  logic [NREQ-1:0]  ready_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic [CW-1:0]    cnt_r;
  logic             rsp_valid_r;
  logic [IDW-1:0]   rsp_id_r;
  logic [WIDTH-1:0] rsp_sum_r;
  logic [WIDTH-1:0] adder_a_r;
  logic [WIDTH-1:0] adder_b_r;

  // (base + off) mod NREQ without a divider; off never exceeds NREQ-1
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input logic [IDW:0] off);
    logic [IDW:0] s;
    s = {1'b0, base} + off;
    if (s >= (IDW+1)'(NREQ)) begin
      s = s - (IDW+1)'(NREQ);
    end else begin
      s = s;
    end
    return s[IDW-1:0];
  endfunction

  // Round-robin search from ptr; descending loop leaves the nearest valid requester
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_add(ptr_r, (IDW+1)'(k))]) begin
        grant_s     = wrap_add(ptr_r, (IDW+1)'(k));
        grant_vld_s = 1'b1;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    op_a_s = '0;
    op_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s == IDW'(i)) begin
        op_a_s = bus.req_a[i*WIDTH +: WIDTH];
        op_b_s = bus.req_b[i*WIDTH +: WIDTH];
      end else begin
        op_a_s = op_a_s;
      end
    end
  end

  // One-hot acceptance strobe, only while idle
  always_comb begin
    ready_s = '0;
    if (state_r == IDLE && grant_vld_s) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Pointer moves past the requester just served
  always_comb begin
    ptr_next_s = '0;
    if (rsp_id_r == IDW'(NREQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = rsp_id_r + IDW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = grant_vld_s ? LAUNCH : IDLE;
      LAUNCH:  state_s = WAIT;
      WAIT:    state_s = (cnt_r == CW'(LAT - 2)) ? RESP : WAIT;
      RESP:    state_s = bus.rsp_ready ? IDLE : RESP;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: operand latch, latency counter, result capture and retirement
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r       <= '0;
      cnt_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_sum_r   <= '0;
      adder_a_r   <= '0;
      adder_b_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            adder_a_r <= op_a_s;
            adder_b_r <= op_b_s;
            rsp_id_r  <= grant_s;
          end
        end
        LAUNCH: cnt_r <= '0;
        WAIT: begin
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(LAT - 2)) begin
            rsp_sum_r   <= bus.adder_out;
            rsp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            ptr_r       <= ptr_next_s;
          end
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_sum   = rsp_sum_r;
  assign bus.adder_en  = (state_r == LAUNCH);
  assign bus.adder_a   = adder_a_r;
  assign bus.adder_b   = adder_b_r;
  assign bus.busy      = (state_r != IDLE);
endmodule

// File: tb/tb_add_serial_sched.sv
// Directed self-checking bench for add_serial_sched with a behavioural serial-adder model.
module tb_add_serial_sched;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int LAT   = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  add_serial_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();
  add_serial_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Adder model: mode 1 drives 0xAA except in the one cycle the result must be sampled
  logic       model_mode = 1'b0;
  logic [3:0] model_cnt  = 4'd0;
  always_ff @(posedge clk) begin
    if (bus.adder_en) model_cnt <= 4'd1;
    else if (model_cnt != 4'd0 && model_cnt != 4'd15) model_cnt <= model_cnt + 4'd1;
  end
  always_comb begin
    if (model_mode && model_cnt != 4'(LAT - 1)) bus.adder_out = 8'hAA;
    else bus.adder_out = bus.adder_a + bus.adder_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL drain_idle: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    compared++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.adder_en} !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_rsp: got v=%b id=%0d sum=%h en=%b expected all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.adder_en);
    end
    compared++;
    if ({bus.adder_a, bus.adder_b, bus.busy, bus.req_ready} !== 21'h0) begin
      mismatched++;
      $display("FAIL reset_adder: got a=%h b=%h busy=%b ready=%b expected all 0",
               bus.adder_a, bus.adder_b, bus.busy, bus.req_ready);
    end
    rst = 1'b1;
    #1;
  endtask

  task automatic test_single();
    int n;
    bus.req_valid = 4'b0100;
    set_req(2, 8'h35, 8'h4A);
    #1;
    compared++;
    if (bus.req_ready !== 4'b0100) begin
      mismatched++;
      $display("FAIL single_ready: got %b expected 0100", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    compared++;
    if ({bus.adder_en, bus.busy} !== 2'b11) begin
      mismatched++;
      $display("FAIL single_en_c1: got en=%b busy=%b expected 1 1", bus.adder_en, bus.busy);
    end
    step();
    compared++;
    if (bus.adder_en !== 1'b0) begin
      mismatched++;
      $display("FAIL single_en_c2: got %b expected 0", bus.adder_en);
    end
    wait_rsp(n);
    compared++;
    if (n !== 9) begin
      mismatched++;
      $display("FAIL single_latency: rsp_valid at cycle %0d expected 11", n + 2);
    end
    compared++;
    if ({bus.rsp_sum, bus.rsp_id} !== {8'h7F, 2'd2}) begin
      mismatched++;
      $display("FAIL single_result: got sum=%h id=%0d expected 7f 2", bus.rsp_sum, bus.rsp_id);
    end
    step();
    drain();
  endtask

  task automatic test_round_robin();
    int cyc;
    int last;
    int n;
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'h10);
    #1;
    cyc = 0;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (bus.req_ready === 4'b0000 && n < 40) begin
        step();
        n++;
        cyc++;
      end
      compared++;
      if (bus.req_ready !== (4'b0001 << (g % NREQ))) begin
        mismatched++;
        $display("FAIL rr_grant%0d: got %b expected %b", g, bus.req_ready, 4'b0001 << (g % NREQ));
      end
      if (g > 0) begin
        compared++;
        if (cyc - last !== 12) begin
          mismatched++;
          $display("FAIL rr_spacing%0d: got %0d cycles expected 12", g, cyc - last);
        end
      end
      last = cyc;
      step();
      cyc++;
      if (g == 4) bus.req_valid = 4'b0000;
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    bus.req_valid = 4'b0010;
    set_req(1, 8'h12, 8'h34);
    bus.rsp_ready = 1'b0;
    #1;
    compared++;
    if (bus.req_ready !== 4'b0010) begin
      mismatched++;
      $display("FAIL bp_grant: got %b expected 0010", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b1000;
    set_req(3, 8'h05, 8'h06);
    wait_rsp(n);
    compared++;
    if (n !== 10) begin
      mismatched++;
      $display("FAIL bp_latency: got %0d expected 10", n);
    end
    for (int k = 0; k < 5; k++) begin
      compared++;
      if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.req_ready, bus.adder_en, bus.busy}
          !== {1'b1, 8'h46, 2'd1, 4'b0000, 1'b0, 1'b1}) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got v=%b sum=%h id=%0d rdy=%b en=%b busy=%b expected 1 46 1 0000 0 1",
                 k, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.req_ready, bus.adder_en, bus.busy);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    compared++;
    if (bus.req_ready !== 4'b0000) begin
      mismatched++;
      $display("FAIL bp_retire_ready: got %b expected 0000", bus.req_ready);
    end
    step();
    compared++;
    if ({bus.rsp_valid, bus.req_ready} !== 5'b0_1000) begin
      mismatched++;
      $display("FAIL bp_next_grant: got v=%b rdy=%b expected 0 1000", bus.rsp_valid, bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    compared++;
    if ({bus.rsp_sum, bus.rsp_id} !== {8'h0B, 2'd3}) begin
      mismatched++;
      $display("FAIL bp_second: got sum=%h id=%0d expected 0b 3", bus.rsp_sum, bus.rsp_id);
    end
    step();
    drain();
  endtask

  task automatic test_sample_point();
    model_mode = 1'b1;
    bus.req_valid = 4'b0001;
    set_req(0, 8'hFF, 8'h01);
    #1;
    compared++;
    if (bus.req_ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL sp_grant: got %b expected 0001", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      compared++;
      if ({bus.adder_a, bus.adder_b} !== 16'hFF01) begin
        mismatched++;
        $display("FAIL sp_operands_c%0d: got %h/%h expected ff/01", k, bus.adder_a, bus.adder_b);
      end
      step();
    end
    compared++;
    if ({bus.rsp_valid, bus.rsp_sum, bus.adder_a, bus.adder_b} !== {1'b1, 8'h00, 16'hFF01}) begin
      mismatched++;
      $display("FAIL sp_result: got v=%b sum=%h a=%h b=%h expected 1 00 ff 01",
               bus.rsp_valid, bus.rsp_sum, bus.adder_a, bus.adder_b);
    end
    step();
    model_mode = 1'b0;
    drain();
  endtask

  task automatic test_pointer_wrap();
    int n;
    logic [3:0] exp_grant [3];
    logic [3:0] valid_pat [3];
    valid_pat[0] = 4'b0010; exp_grant[0] = 4'b0010;
    valid_pat[1] = 4'b0010; exp_grant[1] = 4'b0010;
    valid_pat[2] = 4'b1110; exp_grant[2] = 4'b0100;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h20, 8'h22);
    for (int r = 0; r < 3; r++) begin
      bus.req_valid = valid_pat[r];
      #1;
      compared++;
      if (bus.req_ready !== exp_grant[r]) begin
        mismatched++;
        $display("FAIL wrap_grant%0d: got %b expected %b", r, bus.req_ready, exp_grant[r]);
      end
      step();
      bus.req_valid = 4'b0000;
      wait_rsp(n);
      compared++;
      if (bus.rsp_sum !== 8'h42) begin
        mismatched++;
        $display("FAIL wrap_sum%0d: got %h expected 42", r, bus.rsp_sum);
      end
      step();
      drain();
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int late;
    bus.req_valid = 4'b1001;
    set_req(0, 8'h10, 8'h20);
    set_req(3, 8'h01, 8'h02);
    #1;
    compared++;
    if (bus.req_ready !== 4'b1000) begin
      mismatched++;
      $display("FAIL rst_first_grant: got %b expected 1000", bus.req_ready);
    end
    for (int k = 0; k < 4; k++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    compared++;
    if ({bus.busy, bus.rsp_valid, bus.adder_en, bus.adder_a, bus.adder_b} !== 19'h0) begin
      mismatched++;
      $display("FAIL rst_cleared: got busy=%b v=%b en=%b a=%h b=%h expected all 0",
               bus.busy, bus.rsp_valid, bus.adder_en, bus.adder_a, bus.adder_b);
    end
    compared++;
    if (bus.req_ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL rst_regrant: got %b expected 0001", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    compared++;
    if ({n[7:0], bus.rsp_id, bus.rsp_sum} !== {8'd10, 2'd0, 8'h30}) begin
      mismatched++;
      $display("FAIL rst_result: got wait=%0d id=%0d sum=%h expected 10 0 30", n, bus.rsp_id, bus.rsp_sum);
    end
    step();
    late = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.rsp_valid === 1'b1) late++;
      step();
    end
    compared++;
    if (late !== 0) begin
      mismatched++;
      $display("FAIL rst_no_stale: got %0d extra response cycles expected 0", late);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sample_point();
    test_pointer_wrap();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
